// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants: IM placement/size, fetch FSM encoding and IM address helper.
package cpu_defs;

  localparam logic [31:0] BASE_ADDR   = 32'h0000_3000;
  localparam int unsigned DEPTH_WORDS = 4096;
  localparam int unsigned AW          = 12;
  localparam logic [31:0] IM_BYTES    = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  // IM word index of a byte address inside the IM window.
  function automatic logic [AW-1:0] im_word_addr(input logic [31:0] byte_addr);
    logic [31:0] off;
    off = byte_addr - BASE_ADDR;
    return off[AW+1:2];
  endfunction

endpackage

// File: rtl/fetch_range_chk.sv
// Combinational fetch-address check: word aligned and inside the IM window.
module fetch_range_chk
  import cpu_defs::*;
(
  input  logic [31:0] npc_i,
  output logic        legal_o
);

  logic [31:0] off;
  logic        aligned;
  logic        in_window;

  // Unsigned 32-bit offset: addresses below BASE_ADDR wrap to huge values and fail.
  assign off       = npc_i - BASE_ADDR;
  assign aligned   = (npc_i[1:0] == 2'b00);
  assign in_window = (off < IM_BYTES);
  assign legal_o   = aligned & in_window;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Owns the IM write port during program load, then drives the F-stage PC with
// stall/redirect handling and traps on illegal fetch addresses.
module im_fetch_ctrl
  import cpu_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   pc,
  output logic          pc_valid,
  output logic [31:0]   fetch_count,
  output logic          fault,
  output logic [31:0]   fault_pc
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        ld_ready_q;
  logic [31:0] fetch_count_q;
  logic        fault_q;
  logic [31:0] fault_pc_q;

  logic [31:0] npc_d;
  logic        npc_legal;

  // Candidate next PC when not stalled; a stalled redirect is dropped since D re-presents it.
  always_comb begin
    npc_d = pc_q + PC_STEP;
    if (redirect) begin
      npc_d = redirect_pc;
    end
  end

  fetch_range_chk u_range_chk (
    .npc_i   (npc_d),
    .legal_o (npc_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOAD;
      pc_q          <= BASE_ADDR;
      pc_valid_q    <= 1'b0;
      ld_ready_q    <= 1'b1;
      fetch_count_q <= 32'd0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          ld_ready_q <= 1'b1;
          pc_valid_q <= 1'b0;
          if (ld_done) begin
            state_q    <= S_RUN;
            pc_q       <= BASE_ADDR;
            pc_valid_q <= 1'b1;
            ld_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          ld_ready_q <= 1'b0;
          if (!stall) begin
            fetch_count_q <= fetch_count_q + 32'd1;
            if (npc_legal) begin
              pc_q <= npc_d;
            end else begin
              // pc keeps the last legal value; the offender is reported separately.
              state_q    <= S_FAULT;
              pc_valid_q <= 1'b0;
              fault_q    <= 1'b1;
              fault_pc_q <= npc_d;
            end
          end
        end
        S_FAULT: begin
          pc_valid_q <= 1'b0;
          ld_ready_q <= 1'b0;
          fault_q    <= 1'b1;
        end
        default: begin
          state_q    <= S_FAULT;
          pc_valid_q <= 1'b0;
          ld_ready_q <= 1'b0;
          fault_q    <= 1'b1;
        end
      endcase
    end
  end

  // Loader writes go straight to the IM; a word offered during reset is dropped.
  assign im_we       = ld_valid & ld_ready_q & ~reset;
  assign im_waddr    = ld_addr;
  assign im_wdata    = ld_data;

  assign ld_ready    = ld_ready_q;
  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign fetch_count = fetch_count_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: vector table plus hand sequences for stall/redirect,
// fault and reset corner cases; the IM itself is modelled here behind the write port.
module tb_im_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        im_we;
  logic [11:0] im_waddr;
  logic [31:0] im_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] fetch_count;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] tb_im [4096];

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        lv;
    logic [11:0] la;
    logic [31:0] ldat;
    logic        done;
    logic        stl;
    logic        rd;
    logic [31:0] rpc;
    logic        e_we;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_rdy;
    logic        e_flt;
    logic [31:0] e_fpc;
    logic        chk_cnt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  im_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .im_we       (im_we),
    .im_waddr    (im_waddr),
    .im_wdata    (im_wdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .fetch_count (fetch_count),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_we) tb_im[im_waddr] <= im_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic lv, input logic [11:0] la,
                       input logic [31:0] ldat, input logic done, input logic stl,
                       input logic rd, input logic [31:0] rpc);
    reset = rst; ld_valid = lv; ld_addr = la; ld_data = ldat;
    ld_done = done; stall = stl; redirect = rd; redirect_pc = rpc;
  endtask

  // Simple cycle: no loader traffic.
  task automatic cyc(input logic rst, input logic done, input logic stl,
                     input logic rd, input logic [31:0] rpc);
    drive(rst, 1'b0, 12'd0, 32'd0, done, stl, rd, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    drive(v.rst, v.lv, v.la, v.ldat, v.done, v.stl, v.rd, v.rpc);
    #1;
    tag = $sformatf("v%0d", idx);
    check({tag, ".im_we"}, 32'(im_we), 32'(v.e_we));
    @(posedge clk);
    #1;
    check({tag, ".pc"},       pc,             v.e_pc);
    check({tag, ".pc_valid"}, 32'(pc_valid),  32'(v.e_pv));
    check({tag, ".ld_ready"}, 32'(ld_ready),  32'(v.e_rdy));
    check({tag, ".fault"},    32'(fault),     32'(v.e_flt));
    check({tag, ".fault_pc"}, fault_pc,       v.e_fpc);
    if (v.chk_cnt) check({tag, ".fetch_count"}, fetch_count, v.e_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4096; i++) tb_im[i] = 32'hA5A5_A5A5;
    drive(1'b1, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    //        rst   lv    la      ldat           done  stl   rd    rpc            we    pc            pv    rdy   flt   fpc           cc    cnt
    tbl[0]  = '{1'b1, 1'b1, 12'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 12'd0, 32'h3C01_1234, 1'b0, 1'b0, 1'b0, 32'd0,         1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 12'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd1};
    tbl[4]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3008, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd2};
    tbl[5]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_300C, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd3};
    tbl[6]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3010, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd4};
    tbl[7]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3014, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd5};
    tbl[8]  = '{1'b0, 1'b1, 12'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3018, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd6};
    tbl[9]  = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b1, 1'b0, 32'd0,         1'b0, 32'h0000_3018, 1'b1, 1'b0, 1'b0, 32'd0,         1'b1, 32'd6};
    tbl[10] = '{1'b0, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b1, 32'h0000_3102, 1'b0, 32'h0000_3018, 1'b0, 1'b0, 1'b1, 32'h0000_3102, 1'b0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 12'd3, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h0000_3200, 1'b0, 32'h0000_3018, 1'b0, 1'b0, 1'b1, 32'h0000_3102, 1'b0, 32'd0};
    tbl[12] = '{1'b1, 1'b0, 12'd0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], i);
      if (i == 2) begin
        check("im0_loaded", tb_im[0], 32'h3C01_1234);
        check("im1_loaded", tb_im[1], 32'h0000_0000);
        check("im5_reset_drop", tb_im[5], 32'hA5A5_A5A5);
      end
      if (i == 8) check("im0_run_refused", tb_im[0], 32'h3C01_1234);
      if (i == 11) check("im3_fault_refused", tb_im[3], 32'hA5A5_A5A5);
    end

    // Stall and redirect in the same cycle: redirect dropped until stall clears.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("stl.pc_before", pc, 32'h0000_3008);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3100);
    check("stl.pc_held", pc, 32'h0000_3008);
    check("stl.cnt_held", fetch_count, 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3100);
    check("stl.pc_redir", pc, 32'h0000_3100);
    check("stl.cnt", fetch_count, 32'd3);

    // Redirect beyond the IM window.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_7000);
    check("hi.fault", 32'(fault), 32'd1);
    check("hi.fault_pc", fault_pc, 32'h0000_7000);
    check("hi.pc", pc, 32'h0000_3100);
    check("hi.pc_valid", 32'(pc_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
    check("hi.pc_frozen", pc, 32'h0000_3100);
    check("hi.fault_sticky", 32'(fault), 32'd1);

    // Sequential run-off past the last IM word.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6FF8);
    check("end.pc_6ff8", pc, 32'h0000_6FF8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("end.pc_6ffc", pc, 32'h0000_6FFC);
    check("end.no_fault", 32'(fault), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("end.fault", 32'(fault), 32'd1);
    check("end.fault_pc", fault_pc, 32'h0000_7000);
    check("end.pc", pc, 32'h0000_6FFC);

    // Reset mid-RUN, then prove LOAD is active again via a loader write.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
    check("rst.pc_3040", pc, 32'h0000_3040);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rst.pc", pc, 32'h0000_3000);
    check("rst.cnt", fetch_count, 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.ld_ready", 32'(ld_ready), 32'd1);
    check("rst.pc_valid", 32'(pc_valid), 32'd0);
    drive(1'b0, 1'b1, 12'd2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    check("rst.im_we", 32'(im_we), 32'd1);
    @(posedge clk);
    #1;
    check("rst.im2", tb_im[2], 32'h1234_5678);

    // Target below BASE_ADDR wraps in the unsigned offset and must fault.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2FFC);
    check("lo.fault", 32'(fault), 32'd1);
    check("lo.fault_pc", fault_pc, 32'h0000_2FFC);
    check("lo.pc", pc, 32'h0000_3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
